// File: rtl/ooo_pkg.sv
// Shared out-of-order front-end types: decoded instruction entry, execution
// unit classes and instruction-buffer sizing defaults (also used by fetch).
package ooo_pkg;

  localparam int IBUF_DEPTH  = 16;
  localparam int IBUF_DISP_W = 2;
  localparam int FETCH_W     = 4;
  localparam int OWNER_W     = 4;

  typedef enum logic [1:0] {
    UNIT_NONE = 2'd0,
    UNIT_FXU  = 2'd1,
    UNIT_LSU  = 2'd2,
    UNIT_BRU  = 2'd3
  } unit_t;

  typedef struct packed {
    logic [5:0]         opcode;
    logic [4:0]         rt;
    logic [4:0]         ra;
    logic [4:0]         rb;
    logic               op_a_local_dep;
    logic [OWNER_W-1:0] op_a_owner;
    logic               op_b_local_dep;
    logic [OWNER_W-1:0] op_b_owner;
    logic               uses_rb;
    logic               is_ld_str;
    logic               is_fxu;
    logic               is_branch;
  } ibuf_entry_t;

  // Decode flags never overlap from a correct decoder; fxu wins if they do.
  function automatic unit_t entry_unit(input ibuf_entry_t e);
    if (e.is_fxu)         return UNIT_FXU;
    else if (e.is_ld_str) return UNIT_LSU;
    else if (e.is_branch) return UNIT_BRU;
    else                  return UNIT_NONE;
  endfunction

endpackage

// File: rtl/ibuf_disp_sel.sv
// In-order dispatch lane selector: a lane issues only if all older lanes issue,
// its unit is ready, and no older lane this cycle already claimed that unit.
module ibuf_disp_sel
  import ooo_pkg::*;
#(
  parameter int DISP_W = IBUF_DISP_W
) (
  input  logic [DISP_W-1:0] cand_valid,
  input  unit_t             cand_unit [DISP_W],
  input  logic              fxu_ready,
  input  logic              lsu_ready,
  input  logic              bru_ready,
  output logic [DISP_W-1:0] disp_valid
);

  logic open;
  logic unit_ok;
  logic fxu_used;
  logic lsu_used;
  logic bru_used;

  always_comb begin
    disp_valid = '0;
    open       = 1'b1;
    unit_ok    = 1'b0;
    fxu_used   = 1'b0;
    lsu_used   = 1'b0;
    bru_used   = 1'b0;
    for (int k = 0; k < DISP_W; k++) begin
      case (cand_unit[k])
        UNIT_FXU: unit_ok = fxu_ready && !fxu_used;
        UNIT_LSU: unit_ok = lsu_ready && !lsu_used;
        UNIT_BRU: unit_ok = bru_ready && !bru_used;
        default:  unit_ok = 1'b1;
      endcase
      open          = open && cand_valid[k] && unit_ok;
      disp_valid[k] = open;
      fxu_used      = fxu_used | (open && (cand_unit[k] == UNIT_FXU));
      lsu_used      = lsu_used | (open && (cand_unit[k] == UNIT_LSU));
      bru_used      = bru_used | (open && (cand_unit[k] == UNIT_BRU));
    end
  end

endmodule

// File: rtl/instr_buffer.sv
// Circular instruction buffer between fetch and dispatch. Optional same-cycle
// bypass of an empty buffer is enabled by defining IBUF_BYPASS_EN.
module instr_buffer
  import ooo_pkg::*;
#(
  parameter int DEPTH  = IBUF_DEPTH,
  parameter int DISP_W = IBUF_DISP_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [2:0]        in_count,
  input  ibuf_entry_t       in_entry [FETCH_W],
  output logic [2:0]        num_free,
  input  logic              flush,
  input  logic              fxu_ready,
  input  logic              lsu_ready,
  input  logic              bru_ready,
  output logic [DISP_W-1:0] disp_valid,
  output ibuf_entry_t       disp_entry [DISP_W],
  output logic              ovf_err
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [AW-1:0]     head;
  logic [AW-1:0]     tail;
  logic [AW:0]       count;
  logic [AW:0]       free_cnt;
  logic              ovf_q;
  ibuf_entry_t       mem [DEPTH];

  logic [2:0]        req_n;
  logic [2:0]        enq_n;
  logic [2:0]        wr_n;
  logic [2:0]        skip_n;
  logic [AW:0]       deq_n;
  logic [AW:0]       head_adv;
  logic              ovf_set;
  logic [DISP_W-1:0] cand_valid;
  ibuf_entry_t       cand_entry [DISP_W];
  unit_t             cand_unit  [DISP_W];

  // Fetch width depends on registered occupancy only, never on this cycle's traffic.
  assign free_cnt = DEPTH_C - count;
  assign num_free = (free_cnt >= (AW+1)'(FETCH_W)) ? 3'(FETCH_W) : free_cnt[2:0];

  assign req_n   = !in_valid ? 3'd0 :
                   (in_count > 3'(FETCH_W)) ? 3'(FETCH_W) : in_count;
  assign ovf_set = (AW+1)'(req_n) > free_cnt;
  assign enq_n   = ovf_set ? free_cnt[2:0] : req_n;

`ifdef IBUF_BYPASS_EN
  logic bypass;
  assign bypass = (count == '0) && in_valid;
`endif

  always_comb begin
    for (int k = 0; k < DISP_W; k++) begin
      cand_valid[k] = count > (AW+1)'(k);
      cand_entry[k] = mem[head + AW'(k)];
    end
`ifdef IBUF_BYPASS_EN
    if (bypass) begin
      for (int k = 0; k < DISP_W; k++) begin
        cand_valid[k] = (k < FETCH_W) && (3'(k) < enq_n);
        cand_entry[k] = in_entry[k % FETCH_W];
      end
    end
`endif
    for (int k = 0; k < DISP_W; k++) begin
      cand_unit[k] = entry_unit(cand_entry[k]);
    end
  end

  ibuf_disp_sel #(
    .DISP_W (DISP_W)
  ) u_disp_sel (
    .cand_valid (cand_valid),
    .cand_unit  (cand_unit),
    .fxu_ready  (fxu_ready),
    .lsu_ready  (lsu_ready),
    .bru_ready  (bru_ready),
    .disp_valid (disp_valid)
  );

  assign disp_entry = cand_entry;
  assign ovf_err    = ovf_q;

  always_comb begin
    deq_n = '0;
    for (int k = 0; k < DISP_W; k++) begin
      deq_n = deq_n + (AW+1)'(disp_valid[k]);
    end
  end

  // Bypassed entries leave straight from the fetch group and skip storage.
`ifdef IBUF_BYPASS_EN
  assign skip_n   = bypass ? deq_n[2:0] : 3'd0;
  assign head_adv = bypass ? '0 : deq_n;
`else
  assign skip_n   = 3'd0;
  assign head_adv = deq_n;
`endif
  assign wr_n = enq_n - skip_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (ovf_set) begin
        ovf_q <= 1'b1;
      end
      if (flush) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        head  <= head + head_adv[AW-1:0];
        tail  <= tail + AW'(wr_n);
        count <= count + (AW+1)'(wr_n) - head_adv;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!flush) begin
      for (int i = 0; i < FETCH_W; i++) begin
        if (3'(i) < wr_n) begin
          mem[tail + AW'(i)] <= in_entry[2'(skip_n + 3'(i))];
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_buffer.sv
// Scoreboard bench for instr_buffer: a queue-based model predicts each cycle's
// outputs, a negedge monitor compares them against the DUT.
module tb_instr_buffer;
  import ooo_pkg::*;

  localparam int DEPTH  = 16;
  localparam int DISP_W = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid;
  logic [2:0]        in_count;
  ibuf_entry_t       in_entry [FETCH_W];
  logic [2:0]        num_free;
  logic              flush;
  logic              fxu_ready;
  logic              lsu_ready;
  logic              bru_ready;
  logic [DISP_W-1:0] disp_valid;
  ibuf_entry_t       disp_entry [DISP_W];
  logic              ovf_err;

  always #5 clk = ~clk;

  instr_buffer #(
    .DEPTH  (DEPTH),
    .DISP_W (DISP_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_count   (in_count),
    .in_entry   (in_entry),
    .num_free   (num_free),
    .flush      (flush),
    .fxu_ready  (fxu_ready),
    .lsu_ready  (lsu_ready),
    .bru_ready  (bru_ready),
    .disp_valid (disp_valid),
    .disp_entry (disp_entry),
    .ovf_err    (ovf_err)
  );

  typedef struct packed {
    logic [DISP_W-1:0]              mask;
    ibuf_entry_t [DISP_W-1:0]       ents;
    logic [2:0]                     nf;
    logic                           ovf;
  } exp_t;

  exp_t        expq [$];
  ibuf_entry_t mq   [$];
  logic        m_ovf = 1'b0;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  exp_t        mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (expq.size() != 0) begin
      mon_e = expq.pop_front();
      chk("disp_valid", 64'(disp_valid), 64'(mon_e.mask));
      chk("num_free", 64'(num_free), 64'(mon_e.nf));
      chk("ovf_err", 64'(ovf_err), 64'(mon_e.ovf));
      for (int k = 0; k < DISP_W; k++) begin
        if (mon_e.mask[k] && disp_valid[k]) begin
          chk($sformatf("disp_entry%0d", k), 64'(disp_entry[k]), 64'(mon_e.ents[k]));
        end
      end
    end
  end

  // u: 0 none, 1 fxu, 2 lsu, 3 bru
  function automatic ibuf_entry_t mk_entry(input int u);
    ibuf_entry_t e;
    e.opcode         = 6'($urandom);
    e.rt             = 5'($urandom);
    e.ra             = 5'($urandom);
    e.rb             = 5'($urandom);
    e.op_a_local_dep = 1'($urandom);
    e.op_a_owner     = 4'($urandom);
    e.op_b_local_dep = 1'($urandom);
    e.op_b_owner     = 4'($urandom);
    e.uses_rb        = 1'($urandom);
    e.is_fxu         = (u == 1);
    e.is_ld_str      = (u == 2);
    e.is_branch      = (u == 3);
    return e;
  endfunction

  function automatic int unit_of(input ibuf_entry_t e);
    if (e.is_fxu)    return 1;
    if (e.is_ld_str) return 2;
    if (e.is_branch) return 3;
    return 0;
  endfunction

  task automatic fill(input int u0, input int u1, input int u2, input int u3);
    in_entry[0] = mk_entry(u0);
    in_entry[1] = mk_entry(u1);
    in_entry[2] = mk_entry(u2);
    in_entry[3] = mk_entry(u3);
  endtask

  // Drive one cycle, predict its outputs from the model, then update the model.
  task automatic step(input logic v, input int n, input logic fr, input logic lr,
                      input logic br, input logic fl);
    exp_t        e;
    ibuf_entry_t cand [$];
    bit          taken [4];
    bit          rdy [4];
    bit          byp;
    int          free, req, nacc, deq, u;
    in_valid  = v;
    in_count  = 3'(n);
    fxu_ready = fr;
    lsu_ready = lr;
    bru_ready = br;
    flush     = fl;
    rdy[0] = 1; rdy[1] = fr; rdy[2] = lr; rdy[3] = br;
    for (int i = 0; i < 4; i++) taken[i] = 0;
    free = DEPTH - mq.size();
    req  = v ? n : 0;
    nacc = (req < free) ? req : free;
    byp  = 0;
`ifdef IBUF_BYPASS_EN
    byp = (mq.size() == 0) && v;
`endif
    if (byp) begin
      for (int i = 0; i < nacc; i++) cand.push_back(in_entry[i]);
    end else begin
      for (int i = 0; i < mq.size() && i < DISP_W; i++) cand.push_back(mq[i]);
    end
    e   = '0;
    deq = 0;
    for (int k = 0; k < DISP_W; k++) begin
      if (k >= cand.size()) break;
      u = unit_of(cand[k]);
      if (u != 0 && (!rdy[u] || taken[u])) break;
      taken[u]  = 1;
      e.mask[k] = 1'b1;
      e.ents[k] = cand[k];
      deq++;
    end
    e.nf  = (free >= 4) ? 3'd4 : 3'(free);
    e.ovf = m_ovf;
    expq.push_back(e);
    if (req > free) m_ovf = 1'b1;
    if (fl) begin
      mq.delete();
    end else begin
      if (!byp) repeat (deq) void'(mq.pop_front());
      for (int i = (byp ? deq : 0); i < nacc; i++) mq.push_back(in_entry[i]);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic fr, input logic lr, input logic br);
    step(1'b0, 0, fr, lr, br, 1'b0);
  endtask

  // Reset asserted mid-cycle while a full group is being offered.
  task automatic reset_mid();
    exp_t e;
    fill($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
    in_valid  = 1'b1;
    in_count  = 3'd4;
    fxu_ready = 1'b1;
    lsu_ready = 1'b1;
    bru_ready = 1'b1;
    flush     = 1'b0;
    #2;
    rst_n = 1'b0;
`ifdef IBUF_BYPASS_EN
    in_valid = 1'b0;
`endif
    mq.delete();
    m_ovf = 1'b0;
    e     = '0;
    e.nf  = 3'd4;
    expq.push_back(e);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    in_valid  = 1'b0;
    in_count  = 3'd0;
    flush     = 1'b0;
    fxu_ready = 1'b0;
    lsu_ready = 1'b0;
    bru_ready = 1'b0;
    fill(0, 0, 0, 0);
    @(posedge clk);
    #1;
    idle(1'b0, 1'b0, 1'b0);
    idle(1'b1, 1'b1, 1'b1);
    rst_n = 1'b1;

    // Fill to 16 with nothing ready; head is fxu so nothing leaves.
    fill(1, 1, 1, 2);
    step(1'b1, 4, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int g = 0; g < 3; g++) begin
      fill($urandom_range(1, 3), $urandom_range(1, 3), $urandom_range(1, 3), $urandom_range(1, 3));
      step(1'b1, 4, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    idle(1'b0, 1'b0, 1'b0);

    // fxu,fxu -> one lane; fxu,lsu -> two lanes.
    idle(1'b1, 1'b0, 1'b0);
    idle(1'b1, 1'b0, 1'b0);
    idle(1'b1, 1'b1, 1'b0);
    idle(1'b0, 1'b0, 1'b0);

    // Reach 15, then overflow with a 3-entry group; flag stays set.
    fill(1, 2, 3, 1);
    step(1'b1, 3, 1'b0, 1'b0, 1'b0, 1'b0);
    fill(2, 3, 1, 2);
    step(1'b1, 3, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1'b0, 1'b0, 1'b0);
    idle(1'b0, 1'b0, 1'b0);

    // Move tail to 14, drain, then enqueue a group that wraps 14,15,0,1.
    step(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int g = 0; g < 3; g++) begin
      fill(1, 1, 1, 1);
      step(1'b1, 4, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    fill(1, 1, 0, 0);
    step(1'b1, 2, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 16; c++) idle(1'b1, 1'b1, 1'b1);
    fill(1, 1, 1, 1);
    step(1'b1, 4, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 5; c++) idle(1'b1, 1'b0, 1'b0);

    // Flush overrides enqueue and dispatch in the same cycle.
    fill(1, 2, 3, 0);
    step(1'b1, 4, 1'b0, 1'b0, 1'b0, 1'b0);
    fill(0, 1, 2, 3);
    step(1'b1, 4, 1'b1, 1'b1, 1'b1, 1'b1);
    idle(1'b1, 1'b1, 1'b1);
    idle(1'b1, 1'b1, 1'b1);

    reset_mid();
    fill(0, 1, 2, 3);
    step(1'b1, 4, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1'b1, 1'b1, 1'b1);

    for (int c = 0; c < 3000; c++) begin
      if (c % 600 == 599) begin
        reset_mid();
      end else begin
        fill($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
        step(1'($urandom_range(0, 1)), $urandom_range(0, 4),
             ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
             ($urandom_range(0, 3) != 0), ($urandom_range(0, 39) == 0));
      end
    end

    in_valid = 1'b0;
    flush    = 1'b0;
    @(negedge clk);
    #1;
    chk("scoreboard_drained", 64'(expq.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "timeout");
  end

endmodule
